// File: rtl/dual_port_memory_stream_reader_if.sv
// Purpose: bundles the request, memory read-port and byte-stream signals of
// dual_port_memory_stream_reader so that one port carries the whole bus.
// Signals:
//   start / start_addr / length      transfer request (into the reader)
//   mem_read_clock_enable / mem_read_enable / mem_read_addr
//                                    memory read strobe side (out of the reader)
//   mem_read_data                    registered memory output (into the reader)
//   out_data / out_valid / out_ready valid/ready byte stream
//   busy / done / range_error        transfer status (out of the reader)
// Modports: master = the reader itself, slave = the surrounding environment.
interface dual_port_memory_stream_reader_if;
    logic       start;
    logic [8:0] start_addr;
    logic [9:0] length;
    logic       mem_read_clock_enable;
    logic       mem_read_enable;
    logic [8:0] mem_read_addr;
    logic [7:0] mem_read_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       range_error;

    modport master (
        input  start, start_addr, length, mem_read_data, out_ready,
        output mem_read_clock_enable, mem_read_enable, mem_read_addr,
               out_data, out_valid, busy, done, range_error
    );

    modport slave (
        output start, start_addr, length, mem_read_data, out_ready,
        input  mem_read_clock_enable, mem_read_enable, mem_read_addr,
               out_data, out_valid, busy, done, range_error
    );
endinterface

// File: rtl/dual_port_memory_stream_reader.sv
// Purpose: consumer end of the 512x8 dual-port buffer memory. A request
// (start_addr, length) is drained from the memory read port and delivered as
// a valid/ready byte stream at up to one byte per cycle. The memory's one
// cycle read latency is absorbed by a small output FIFO; reads are only
// issued when the FIFO is guaranteed to have room for the returning byte.
// Ports:
//   clock  system clock (posedge)
//   reset  synchronous, active-high
//   bus    dual_port_memory_stream_reader_if.master (request, memory read
//          port, byte stream, busy/done/range_error status)
// Configuration:
//   BUFFER_DEPTH                            output FIFO entries, 3..8
//   DUAL_PORT_MEMORY_STREAM_READER_WRAP_EN  when defined, addresses wrap
//          modulo 512 and range_error stays 0; otherwise a request running
//          past address 511 is rejected with done + range_error.
module dual_port_memory_stream_reader #(
    parameter int BUFFER_DEPTH = 4
) (
    input logic clock,
    input logic reset,
    dual_port_memory_stream_reader_if.master bus
);
    localparam int PTR_W = $clog2(BUFFER_DEPTH);
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [8:0]       start_addr_q, start_addr_d;
    logic [9:0]       length_q, length_d;
    logic [9:0]       reads_issued_q, reads_issued_d;
    logic [9:0]       bytes_sent_q, bytes_sent_d;
    logic             issued_q, issued_d;
    logic             range_error_q, range_error_d;
    logic [7:0]       buf_q [BUFFER_DEPTH];
    logic [7:0]       buf_d [BUFFER_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             range_err_s;
    logic [OCC_W-1:0] occ_sum_s;
    logic             issue_s;
    logic             out_valid_s;
    logic             pop_s;

    // Circular pointer advance for a FIFO whose depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUFFER_DEPTH - 1)) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Out-of-range request detection (absent when addresses wrap).
`ifdef DUAL_PORT_MEMORY_STREAM_READER_WRAP_EN
    assign range_err_s = 1'b0;
`else
    assign range_err_s = ({2'b00, bus.start_addr} + {1'b0, bus.length}) > 11'd512;
`endif

    // Room check counts the byte already in flight so a capture never overflows the FIFO.
    assign occ_sum_s   = OCC_W'(count_q) + OCC_W'(issued_q) + OCC_W'(1'b1);
    assign issue_s     = (state_q == ST_RUN) && (reads_issued_q < length_q)
                         && (occ_sum_s <= OCC_W'(BUFFER_DEPTH));
    assign out_valid_s = (count_q != CNT_W'(0));
    assign pop_s       = out_valid_s && bus.out_ready;

    assign bus.mem_read_clock_enable = 1'b1;
    assign bus.mem_read_enable       = issue_s;
    assign bus.mem_read_addr         = start_addr_q + reads_issued_q[8:0];
    assign bus.out_valid             = out_valid_s;
    assign bus.out_data              = out_valid_s ? buf_q[rd_ptr_q] : 8'h00;
    assign bus.busy                  = (state_q == ST_RUN);
    assign bus.done                  = (state_q == ST_FINISH);
    assign bus.range_error           = range_error_q;

    // Next-state logic: request latch, read issue, FIFO capture/drain, counters.
    always_comb begin
        state_d        = state_q;
        start_addr_d   = start_addr_q;
        length_d       = length_q;
        reads_issued_d = reads_issued_q;
        bytes_sent_d   = bytes_sent_q;
        issued_d       = 1'b0;
        range_error_d  = 1'b0;
        buf_d          = buf_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    start_addr_d   = bus.start_addr;
                    length_d       = bus.length;
                    reads_issued_d = 10'd0;
                    bytes_sent_d   = 10'd0;
                    if (range_err_s) begin
                        state_d       = ST_FINISH;
                        range_error_d = 1'b1;
                    end else if (bus.length == 10'd0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    reads_issued_d = reads_issued_q + 10'd1;
                    issued_d       = 1'b1;
                end else begin
                    issued_d = 1'b0;
                end
                // The memory holds its output between strobes, so capture
                // follows the registered strobe flag, not the data.
                if (issued_q) begin
                    buf_d[wr_ptr_q] = bus.mem_read_data;
                    wr_ptr_d        = ptr_inc(wr_ptr_q);
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
                if (pop_s) begin
                    rd_ptr_d     = ptr_inc(rd_ptr_q);
                    bytes_sent_d = bytes_sent_q + 10'd1;
                    if ((bytes_sent_q + 10'd1) == length_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
                case ({issued_q, pop_s})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
            ST_FINISH: begin
                state_d  = ST_IDLE;
                wr_ptr_d = PTR_W'(0);
                rd_ptr_d = PTR_W'(0);
                count_d  = CNT_W'(0);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            start_addr_q   <= 9'd0;
            length_q       <= 10'd0;
            reads_issued_q <= 10'd0;
            bytes_sent_q   <= 10'd0;
            issued_q       <= 1'b0;
            range_error_q  <= 1'b0;
            buf_q          <= '{default: 8'h00};
            wr_ptr_q       <= PTR_W'(0);
            rd_ptr_q       <= PTR_W'(0);
            count_q        <= CNT_W'(0);
        end else begin
            state_q        <= state_d;
            start_addr_q   <= start_addr_d;
            length_q       <= length_d;
            reads_issued_q <= reads_issued_d;
            bytes_sent_q   <= bytes_sent_d;
            issued_q       <= issued_d;
            range_error_q  <= range_error_d;
            buf_q          <= buf_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end
endmodule

// File: tb/tb_dual_port_memory_stream_reader.sv
// Directed testbench for dual_port_memory_stream_reader. A behavioural
// 512x8 memory with a registered read port feeds the reader; expected bytes
// and read addresses are queued when each request is driven and popped as
// the reader strobes the memory and hands bytes over.
module tb_dual_port_memory_stream_reader;
    localparam int BUFFER_DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    dual_port_memory_stream_reader_if bus_if ();

    dual_port_memory_stream_reader #(.BUFFER_DEPTH(BUFFER_DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [7:0] mem [0:511];

    initial bus_if.mem_read_data = 8'h00;

    // Registered read port: data appears the cycle after a strobe and holds otherwise.
    always @(posedge clock) begin
        if (bus_if.mem_read_enable) begin
            bus_if.mem_read_data <= mem[bus_if.mem_read_addr];
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t0, popped, strobes, done_cnt, done_cyc, range_cnt, range_cyc;
    int first_valid, first_busy, last_hs, occ;
    logic       prev_strobe = 1'b0;
    logic       prev_stall  = 1'b0;
    logic [7:0] prev_d      = 8'h00;
    logic [7:0] exp_q [$];
    logic [8:0] exp_addr_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        popped = 0; strobes = 0; done_cnt = 0; done_cyc = -1;
        range_cnt = 0; range_cyc = -1; first_valid = -1; first_busy = -1; last_hs = -1;
    endtask

    // One clock cycle: sample at the falling edge, then advance past the rising edge.
    task automatic cycle();
        logic v, r, hs;
        logic [7:0] d;
        @(negedge clock);
        v = bus_if.out_valid; r = bus_if.out_ready; d = bus_if.out_data;
        hs = v && r;
        chk("valid_vs_occupancy", v, (occ != 0));
        if (prev_stall) begin
            chk("stall_valid_held", v, 1'b1);
            chk("stall_data_held", d, prev_d);
        end
        if (v && first_valid < 0) first_valid = cyc;
        if (bus_if.busy && first_busy < 0) first_busy = cyc;
        if (hs) begin
            if (exp_q.size() == 0) chk("byte_expected", exp_q.size(), 1);
            else chk("stream_byte", d, exp_q.pop_front());
            popped++;
            last_hs = cyc;
        end
        if (bus_if.mem_read_enable) begin
            strobes++;
            chk("issue_has_room", (occ + int'(prev_strobe) + 1) <= BUFFER_DEPTH, 1'b1);
            if (exp_addr_q.size() == 0) chk("strobe_expected", exp_addr_q.size(), 1);
            else chk("read_addr", bus_if.mem_read_addr, exp_addr_q.pop_front());
        end
        if (bus_if.done) begin done_cnt++; done_cyc = cyc; end
        if (bus_if.range_error) begin range_cnt++; range_cyc = cyc; end
        occ = occ + int'(prev_strobe) - int'(hs);
        prev_strobe = bus_if.mem_read_enable;
        prev_stall  = v && !r;
        prev_d      = d;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_start(input logic [8:0] addr, input logic [9:0] len);
        logic legal;
        logic [8:0] a;
`ifdef DUAL_PORT_MEMORY_STREAM_READER_WRAP_EN
        legal = 1'b1;
`else
        legal = (int'(addr) + int'(len)) <= 512;
`endif
        if (legal) begin
            for (int i = 0; i < int'(len); i++) begin
                a = addr + 9'(i);
                exp_addr_q.push_back(a);
                exp_q.push_back(mem[a]);
            end
        end
        clear_stats();
        bus_if.start = 1'b1; bus_if.start_addr = addr; bus_if.length = len;
        t0 = cyc;
        cycle();
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("done_within_budget", (done_cnt != 0), 1'b1);
        cycle();
        cycle();
    endtask

    task automatic scenario_basic(input string tag);
        bus_if.out_ready = 1'b1;
        do_start(9'h010, 10'd4);
        wait_done(50);
        chk({tag, "_first_valid_latency"}, first_valid - t0, 3);
        chk({tag, "_busy_next_cycle"}, first_busy - t0, 1);
        chk({tag, "_bytes_back_to_back"}, last_hs - first_valid, 3);
        chk({tag, "_done_after_last"}, done_cyc - last_hs, 1);
        chk({tag, "_done_one_cycle"}, done_cnt, 1);
        chk({tag, "_strobes"}, strobes, 4);
        chk({tag, "_all_bytes"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 4; i++) mem[16 + i] = 8'hA0 + 8'(i);
        occ = 0;
        clear_stats();
        bus_if.start = 1'b0; bus_if.start_addr = 9'h000; bus_if.length = 10'd0;
        bus_if.out_ready = 1'b0;

        // Reset state
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_out_valid", bus_if.out_valid, 1'b0);
        chk("rst_out_data", bus_if.out_data, 8'h00);
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_done", bus_if.done, 1'b0);
        chk("rst_range_error", bus_if.range_error, 1'b0);
        chk("rst_mem_re", bus_if.mem_read_enable, 1'b0);
        chk("rst_mem_cke", bus_if.mem_read_clock_enable, 1'b1);

        // Four bytes from 0x010 under continuous ready
        scenario_basic("s1");

        // Sixteen bytes with ready toggling 1,0,0,1
        bus_if.out_ready = 1'b1;
        do_start(9'h000, 10'd16);
        n = 1;
        while (done_cnt == 0 && n < 200) begin
            bus_if.out_ready = ((n % 4) == 0) || ((n % 4) == 3);
            cycle();
            n++;
        end
        chk("s2_done_within_budget", (done_cnt != 0), 1'b1);
        bus_if.out_ready = 1'b1;
        cycle();
        chk("s2_all_bytes", exp_q.size(), 0);
        chk("s2_strobes", strobes, 16);
        chk("s2_done_one_cycle", done_cnt, 1);

        // Zero-length request
        do_start(9'h050, 10'd0);
        wait_done(10);
        chk("s3_no_strobes", strobes, 0);
        chk("s3_done_next_cycle", done_cyc - t0, 1);
        chk("s3_busy_never", first_busy, -1);

        // Request crossing the top of memory
        do_start(9'h1FE, 10'd4);
        wait_done(50);
`ifdef DUAL_PORT_MEMORY_STREAM_READER_WRAP_EN
        chk("s4_wrap_strobes", strobes, 4);
        chk("s4_wrap_all_bytes", exp_q.size(), 0);
        chk("s4_wrap_no_range_error", range_cnt, 0);
`else
        chk("s4_reject_strobes", strobes, 0);
        chk("s4_reject_done_next", done_cyc - t0, 1);
        chk("s4_range_error_once", range_cnt, 1);
        chk("s4_range_error_with_done", range_cyc - done_cyc, 0);
`endif

        // Reset after ten bytes of a 100-byte transfer
        do_start(9'h100, 10'd100);
        n = 0;
        while (popped < 10 && n < 300) begin
            cycle();
            n++;
        end
        chk("s5_ten_bytes", (popped >= 10), 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_q.delete(); exp_addr_q.delete();
        occ = 0; prev_strobe = 1'b0; prev_stall = 1'b0;
        chk("s5_valid_cleared", bus_if.out_valid, 1'b0);
        chk("s5_busy_cleared", bus_if.busy, 1'b0);
        chk("s5_no_done", bus_if.done, 1'b0);
        clear_stats();
        for (int i = 0; i < 5; i++) cycle();
        chk("s5_quiet_done", done_cnt, 0);
        chk("s5_quiet_strobes", strobes, 0);
        scenario_basic("s5_restart");

        // A second start while busy is ignored
        bus_if.out_ready = 1'b1;
        do_start(9'h020, 10'd8);
        cycle();
        cycle();
        bus_if.start = 1'b1; bus_if.start_addr = 9'h1A0; bus_if.length = 10'd2;
        cycle();
        bus_if.start = 1'b0;
        wait_done(60);
        chk("s6_strobes", strobes, 8);
        chk("s6_all_bytes", exp_q.size(), 0);
        chk("s6_done_one_cycle", done_cnt, 1);
        chk("s6_no_stray_reads", exp_addr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
